board_port_arbiter: RTL and testbench

BOARD_PORT_ARBITER -- requirements
Module: board_port_arbiter

---
 rtl/board_pkg.sv | 41 ++++
 rtl/position_to_address.sv | 22 ++
 rtl/board_port_arbiter.sv | 264 ++++++++++++++++++++++++++
 tb/tb_board_port_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : board_pkg
//  Description : Shared board constants for the board port arbiter: cell
//                colours, board geometry, address width and the arbiter
//                state encoding. Also the {Y,X} cell-to-address helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package board_pkg;

   // Board geometry: 16x16 cells, 4-bit coordinates, 8-bit row-major address
   localparam int unsigned c_board_dim = 16;
   localparam int unsigned c_pos_w     = 4;
   localparam int unsigned c_addr_w    = 8;
   localparam int unsigned c_color_w   = 3;

   // Cell colours as stored in the board BRAM
   localparam logic [c_color_w-1:0] c_empty = 3'b000;
   localparam logic [c_color_w-1:0] c_red   = 3'b100;
   localparam logic [c_color_w-1:0] c_blue  = 3'b001;
   localparam logic [c_color_w-1:0] c_clash = 3'b110;

   // Arbiter grant states; every grant state lasts exactly one cycle
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WR_RED   = 3'd1,
      ST_WR_BLUE  = 3'd2,
      ST_WR_MERGE = 3'd3,
      ST_RD_DRAW  = 3'd4
   } arb_state_e;

   // Row-major cell address: Y selects the row (upper nibble), X the column
   function automatic logic [c_addr_w-1:0] cell_addr(
      input logic [c_pos_w-1:0] x,
      input logic [c_pos_w-1:0] y
   );
      return {y, x};
   endfunction

endpackage
`default_nettype wire

// File: rtl/position_to_address.sv
`default_nettype none
// ============================================================================
//  Module      : position_to_address
//  Description : Combinational conversion of a board cell position (X,Y)
//                into its row-major BRAM address {Y,X}.
//  Ports       : i_x    - column, 0..15
//                i_y    - row, 0..15
//                o_addr - 8-bit cell address
//  Revision    : 1.0 - initial release
// ============================================================================
module position_to_address
   import board_pkg::*;
(
   input  logic [c_pos_w-1:0]  i_x,
   input  logic [c_pos_w-1:0]  i_y,
   output logic [c_addr_w-1:0] o_addr
);

   assign o_addr = cell_addr(i_x, i_y);

endmodule
`default_nettype wire

// File: rtl/board_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : board_port_arbiter
//  Description : Shares the single port of the board BRAM between two player
//                cell-write requesters (red, blue) and a renderer cell-read
//                requester (draw). Requests sampled in cycle N produce the
//                registered BRAM command and the one-cycle ack in cycle N+1.
//                Same-cell red/blue writes merge into one CLASH write with a
//                collision pulse. A starvation counter forces a draw grant
//                after STARVE_LIMIT consecutive write grants.
//  Build macro : BOARD_ARB_ROUND_ROBIN_EN - alternate red/blue on
//                different-cell contention (default: fixed red-first).
//  Parameters  : STARVE_LIMIT - max consecutive write grants while draw waits
//                RD_LAT       - BRAM read latency, mem_rden to mem_q (>= 1)
//  Ports       : clock, reset (async, active low)
//                red_req/red_X/red_Y/red_ack      - red write request
//                blue_req/blue_X/blue_Y/blue_ack  - blue write request
//                draw_req/draw_addr/draw_ack      - renderer read request
//                draw_valid/draw_q                - read return
//                mem_address/mem_data/mem_wren/mem_rden/mem_q - BRAM port
//                collision                        - merged same-cell write
//  Revision    : 1.0 - initial release
// ============================================================================
module board_port_arbiter
   import board_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned RD_LAT       = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  red_req,
   input  logic [c_pos_w-1:0]    red_X,
   input  logic [c_pos_w-1:0]    red_Y,
   output logic                  red_ack,
   input  logic                  blue_req,
   input  logic [c_pos_w-1:0]    blue_X,
   input  logic [c_pos_w-1:0]    blue_Y,
   output logic                  blue_ack,
   input  logic                  draw_req,
   input  logic [c_addr_w-1:0]   draw_addr,
   output logic                  draw_ack,
   output logic                  draw_valid,
   output logic [c_color_w-1:0]  draw_q,
   output logic [c_addr_w-1:0]   mem_address,
   output logic [c_color_w-1:0]  mem_data,
   output logic                  mem_wren,
   output logic                  mem_rden,
   input  logic [c_color_w-1:0]  mem_q,
   output logic                  collision
);

   localparam int unsigned c_cnt_w = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [c_cnt_w-1:0] c_starve_max = c_cnt_w'(STARVE_LIMIT);

   // ------------------------------------------------------------------------
   // Cell address conversion
   // ------------------------------------------------------------------------
   logic [c_addr_w-1:0] w_red_addr;
   logic [c_addr_w-1:0] w_blue_addr;

   position_to_address u_red_pos (
      .i_x    (red_X),
      .i_y    (red_Y),
      .o_addr (w_red_addr)
   );

   position_to_address u_blue_pos (
      .i_x    (blue_X),
      .i_y    (blue_Y),
      .o_addr (w_blue_addr)
   );

   // ------------------------------------------------------------------------
   // State and registered outputs
   // ------------------------------------------------------------------------
   arb_state_e            state_q, state_d;
   logic                  red_ack_q, red_ack_d;
   logic                  blue_ack_q, blue_ack_d;
   logic                  draw_ack_q, draw_ack_d;
   logic                  collision_q, collision_d;
   logic                  mem_wren_q, mem_wren_d;
   logic                  mem_rden_q, mem_rden_d;
   logic [c_addr_w-1:0]   mem_address_q, mem_address_d;
   logic [c_color_w-1:0]  mem_data_q, mem_data_d;
   logic [c_cnt_w-1:0]    starve_cnt_q, starve_cnt_d;
   logic [RD_LAT-1:0]     rd_pipe_q, rd_pipe_d;
   logic [RD_LAT-1:0]     w_rd_pipe_next;

   // A requester keeps its req high through its ack cycle (it only sees the
   // ack at the following edge), so a requester being acked right now is
   // not eligible again; otherwise it would be granted twice.
   logic w_red_ok;
   logic w_blue_ok;
   logic w_draw_ok;
   logic w_same_cell;
   logic w_starved;
   logic w_blue_first;

   assign w_red_ok    = red_req  && !((state_q == ST_WR_RED)  || (state_q == ST_WR_MERGE));
   assign w_blue_ok   = blue_req && !((state_q == ST_WR_BLUE) || (state_q == ST_WR_MERGE));
   assign w_draw_ok   = draw_req && (state_q != ST_RD_DRAW);
   assign w_same_cell = (w_red_addr == w_blue_addr);
   assign w_starved   = w_draw_ok && (starve_cnt_q >= c_starve_max);

   // ------------------------------------------------------------------------
   // Red/blue contention priority
   // ------------------------------------------------------------------------
`ifdef BOARD_ARB_ROUND_ROBIN_EN
   // Pointer moves only when a different-cell contention is resolved, so two
   // back-to-back contentions are won by opposite players.
   logic rr_blue_q, rr_blue_d;
   logic w_contend;

   assign w_contend    = w_red_ok && w_blue_ok && !w_same_cell;
   assign w_blue_first = rr_blue_q;

   always_comb begin
      rr_blue_d = rr_blue_q;
      if (w_contend && (state_d == ST_WR_RED)) begin
         rr_blue_d = 1'b1;
      end else if (w_contend && (state_d == ST_WR_BLUE)) begin
         rr_blue_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rr_blue_q <= 1'b0;
      end else begin
         rr_blue_q <= rr_blue_d;
      end
   end
`else
   assign w_blue_first = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // Read-return pipeline: one bit per in-flight read
   // ------------------------------------------------------------------------
   generate
      if (RD_LAT == 1) begin : g_rd_pipe_single
         assign w_rd_pipe_next = mem_rden_q;
      end else begin : g_rd_pipe_multi
         assign w_rd_pipe_next = {rd_pipe_q[RD_LAT-2:0], mem_rden_q};
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Grant decision
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = ST_IDLE;
      if (w_starved) begin
         state_d = ST_RD_DRAW;
      end else if (w_red_ok && w_blue_ok) begin
         if (w_same_cell) begin
            state_d = ST_WR_MERGE;
         end else if (w_blue_first) begin
            state_d = ST_WR_BLUE;
         end else begin
            state_d = ST_WR_RED;
         end
      end else if (w_red_ok) begin
         state_d = ST_WR_RED;
      end else if (w_blue_ok) begin
         state_d = ST_WR_BLUE;
      end else if (w_draw_ok) begin
         state_d = ST_RD_DRAW;
      end
   end

   // ------------------------------------------------------------------------
   // Next values of the registered outputs and the starvation counter
   // ------------------------------------------------------------------------
   always_comb begin
      red_ack_d     = (state_d == ST_WR_RED)  || (state_d == ST_WR_MERGE);
      blue_ack_d    = (state_d == ST_WR_BLUE) || (state_d == ST_WR_MERGE);
      collision_d   = (state_d == ST_WR_MERGE);
      draw_ack_d    = (state_d == ST_RD_DRAW);
      mem_wren_d    = red_ack_d || blue_ack_d;
      mem_rden_d    = draw_ack_d;
      mem_address_d = mem_address_q;
      mem_data_d    = mem_data_q;

      case (state_d)
         ST_WR_RED: begin
            mem_address_d = w_red_addr;
            mem_data_d    = c_red;
         end
         ST_WR_BLUE: begin
            mem_address_d = w_blue_addr;
            mem_data_d    = c_blue;
         end
         ST_WR_MERGE: begin
            mem_address_d = w_red_addr;
            mem_data_d    = c_clash;
         end
         ST_RD_DRAW: begin
            mem_address_d = draw_addr;
         end
         default: begin
         end
      endcase

      // Counts write grants made while a draw is waiting; saturates at the
      // limit, which keeps the draw forced until it is granted.
      starve_cnt_d = starve_cnt_q;
      if (!draw_req || draw_ack_d) begin
         starve_cnt_d = '0;
      end else if (mem_wren_d && w_draw_ok && (starve_cnt_q < c_starve_max)) begin
         starve_cnt_d = starve_cnt_q + c_cnt_w'(1);
      end

      rd_pipe_d = w_rd_pipe_next;
   end

   // ------------------------------------------------------------------------
   // State machine and output registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         red_ack_q     <= 1'b0;
         blue_ack_q    <= 1'b0;
         draw_ack_q    <= 1'b0;
         collision_q   <= 1'b0;
         mem_wren_q    <= 1'b0;
         mem_rden_q    <= 1'b0;
         mem_address_q <= '0;
         mem_data_q    <= c_empty;
         starve_cnt_q  <= '0;
         rd_pipe_q     <= '0;
      end else begin
         state_q       <= state_d;
         red_ack_q     <= red_ack_d;
         blue_ack_q    <= blue_ack_d;
         draw_ack_q    <= draw_ack_d;
         collision_q   <= collision_d;
         mem_wren_q    <= mem_wren_d;
         mem_rden_q    <= mem_rden_d;
         mem_address_q <= mem_address_d;
         mem_data_q    <= mem_data_d;
         starve_cnt_q  <= starve_cnt_d;
         rd_pipe_q     <= rd_pipe_d;
      end
   end

   assign red_ack     = red_ack_q;
   assign blue_ack    = blue_ack_q;
   assign draw_ack    = draw_ack_q;
   assign collision   = collision_q;
   assign mem_wren    = mem_wren_q;
   assign mem_rden    = mem_rden_q;
   assign mem_address = mem_address_q;
   assign mem_data    = mem_data_q;

   // mem_q is only valid in the return cycle, so it is passed straight
   // through; a register here would add a cycle of read latency.
   assign draw_valid  = rd_pipe_q[RD_LAT-1];
   assign draw_q      = draw_valid ? mem_q : c_empty;

endmodule
`default_nettype wire

// File: tb/tb_board_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_board_port_arbiter
//  Description : Self-checking bench for board_port_arbiter. Expected BRAM
//                writes and read returns are queued as stimulus is issued and
//                compared by a negedge monitor when the DUT produces them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_board_port_arbiter;
   import board_pkg::*;

   localparam int unsigned STARVE_LIMIT = 4;
   localparam int unsigned RD_LAT       = 1;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       red_req = 1'b0, blue_req = 1'b0, draw_req = 1'b0;
   logic [3:0] red_X = '0, red_Y = '0, blue_X = '0, blue_Y = '0;
   logic [7:0] draw_addr = '0;
   logic       red_ack, blue_ack, draw_ack, draw_valid, collision;
   logic [2:0] draw_q, mem_data, mem_q;
   logic [7:0] mem_address;
   logic       mem_wren, mem_rden;

   board_port_arbiter #(
      .STARVE_LIMIT (STARVE_LIMIT),
      .RD_LAT       (RD_LAT)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .red_req     (red_req),
      .red_X       (red_X),
      .red_Y       (red_Y),
      .red_ack     (red_ack),
      .blue_req    (blue_req),
      .blue_X      (blue_X),
      .blue_Y      (blue_Y),
      .blue_ack    (blue_ack),
      .draw_req    (draw_req),
      .draw_addr   (draw_addr),
      .draw_ack    (draw_ack),
      .draw_valid  (draw_valid),
      .draw_q      (draw_q),
      .mem_address (mem_address),
      .mem_data    (mem_data),
      .mem_wren    (mem_wren),
      .mem_rden    (mem_rden),
      .mem_q       (mem_q),
      .collision   (collision)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always @(posedge clock) cyc <= cyc + 1;

   // ------------------------------------------------------------------------
   // Board BRAM model with RD_LAT read latency
   // ------------------------------------------------------------------------
   logic [2:0] mem [256];
   logic [2:0] rd_pipe [RD_LAT];

   always @(posedge clock) begin
      if (mem_wren) mem[mem_address] = mem_data;
      rd_pipe[0] <= mem_rden ? mem[mem_address] : 3'b000;
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign mem_q = rd_pipe[RD_LAT-1];

   // ------------------------------------------------------------------------
   // Checking and scoreboard
   // ------------------------------------------------------------------------
   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   typedef struct packed {
      logic [7:0] addr;
      logic [2:0] data;
      logic       ra;
      logic       ba;
      logic       col;
   } wr_exp_t;

   wr_exp_t    exp_wr_q[$];
   logic [2:0] exp_rd_q[$];
   int         rd_due_q[$];

   function automatic wr_exp_t mk_wr(input logic [7:0] a, input logic [2:0] d,
                                     input logic ra, input logic ba, input logic col);
      wr_exp_t e;
      e.addr = a; e.data = d; e.ra = ra; e.ba = ba; e.col = col;
      return e;
   endfunction

   always @(negedge clock) begin
      if (reset) begin
         chk_eq("wren_rden_excl", 32'(mem_wren & mem_rden), 32'd0);
         if (mem_wren) begin
            if (exp_wr_q.size() == 0) chk_eq("unexpected_write", 32'(exp_wr_q.size()), 32'd1);
            else chk_eq("write", 32'({mem_address, mem_data, red_ack, blue_ack, collision}),
                        32'(exp_wr_q.pop_front()));
         end else begin
            chk_eq("ack_without_write", 32'({red_ack, blue_ack, collision}), 32'd0);
         end
         if (mem_rden) rd_due_q.push_back(cyc + RD_LAT);
         if (draw_valid) begin
            if (rd_due_q.size() == 0) chk_eq("unexpected_draw_valid", 32'(rd_due_q.size()), 32'd1);
            else begin
               chk_eq("rd_latency", 32'(cyc), 32'(rd_due_q.pop_front()));
               if (exp_rd_q.size() == 0) chk_eq("unexpected_read_data", 32'(exp_rd_q.size()), 32'd1);
               else chk_eq("draw_q", 32'(draw_q), 32'(exp_rd_q.pop_front()));
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Requester models: raise req, wait for ack, drop after the ack cycle
   // ------------------------------------------------------------------------
   task automatic red_write(input logic [3:0] x, input logic [3:0] y, output int lat);
      int start; bit got;
      red_X = x; red_Y = y; red_req = 1'b1; start = cyc; got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clock);
         if (red_ack) got = 1'b1;
      end
      lat = cyc - start;
      if (!got) chk_eq("red_ack_timeout", 32'(got), 32'd1);
      @(posedge clock); #1;
      red_req = 1'b0;
   endtask

   task automatic blue_write(input logic [3:0] x, input logic [3:0] y, output int lat);
      int start; bit got;
      blue_X = x; blue_Y = y; blue_req = 1'b1; start = cyc; got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clock);
         if (blue_ack) got = 1'b1;
      end
      lat = cyc - start;
      if (!got) chk_eq("blue_ack_timeout", 32'(got), 32'd1);
      @(posedge clock); #1;
      blue_req = 1'b0;
   endtask

   task automatic draw_read(input logic [7:0] a, output int lat);
      int start; bit got;
      draw_addr = a; draw_req = 1'b1; start = cyc; got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clock);
         if (draw_ack) got = 1'b1;
      end
      lat = cyc - start;
      if (!got) chk_eq("draw_ack_timeout", 32'(got), 32'd1);
      @(posedge clock); #1;
      draw_req = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      chk_eq({tag, "_acks"}, 32'({red_ack, blue_ack, draw_ack, collision}), 32'd0);
      chk_eq({tag, "_mem_en"}, 32'({mem_wren, mem_rden}), 32'd0);
      chk_eq({tag, "_mem_address"}, 32'(mem_address), 32'd0);
      chk_eq({tag, "_mem_data"}, 32'(mem_data), 32'd0);
      chk_eq({tag, "_draw"}, 32'({draw_valid, draw_q}), 32'd0);
   endtask

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   int l1, l2, ld;
   bit got_ack;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 3'b000;
      mem[8'h10] = 3'b101;

      // Asynchronous reset before any clock edge
      #2 reset = 1'b0;
      #1 check_all_zero("reset");
      repeat (3) @(posedge clock);
      @(negedge clock) reset = 1'b1;
      @(posedge clock); #1;

      // Single red write at (3,5)
      exp_wr_q.push_back(mk_wr(8'h53, c_red, 1'b1, 1'b0, 1'b0));
      red_write(4'd3, 4'd5, l1);
      chk_eq("red_single_lat", 32'(l1), 32'd1);

      // Same-cell merge at (7,7)
      exp_wr_q.push_back(mk_wr(8'h77, c_clash, 1'b1, 1'b1, 1'b1));
      fork
         red_write(4'd7, 4'd7, l1);
         blue_write(4'd7, 4'd7, l2);
      join
      chk_eq("merge_red_lat", 32'(l1), 32'd1);
      chk_eq("merge_blue_lat", 32'(l2), 32'd1);

      // Different-cell contention: red first
      exp_wr_q.push_back(mk_wr(8'h01, c_red, 1'b1, 1'b0, 1'b0));
      exp_wr_q.push_back(mk_wr(8'h02, c_blue, 1'b0, 1'b1, 1'b0));
      fork
         red_write(4'd1, 4'd0, l1);
         blue_write(4'd2, 4'd0, l2);
      join
      chk_eq("contend1_red_lat", 32'(l1), 32'd1);
      chk_eq("contend1_blue_lat", 32'(l2), 32'd2);

      // Second identical contention
`ifdef BOARD_ARB_ROUND_ROBIN_EN
      exp_wr_q.push_back(mk_wr(8'h02, c_blue, 1'b0, 1'b1, 1'b0));
      exp_wr_q.push_back(mk_wr(8'h01, c_red, 1'b1, 1'b0, 1'b0));
`else
      exp_wr_q.push_back(mk_wr(8'h01, c_red, 1'b1, 1'b0, 1'b0));
      exp_wr_q.push_back(mk_wr(8'h02, c_blue, 1'b0, 1'b1, 1'b0));
`endif
      fork
         red_write(4'd1, 4'd0, l1);
         blue_write(4'd2, 4'd0, l2);
      join
`ifdef BOARD_ARB_ROUND_ROBIN_EN
      chk_eq("contend2_red_lat", 32'(l1), 32'd2);
      chk_eq("contend2_blue_lat", 32'(l2), 32'd1);
`else
      chk_eq("contend2_red_lat", 32'(l1), 32'd1);
      chk_eq("contend2_blue_lat", 32'(l2), 32'd2);
`endif

      // Starvation: draw at 8'h10 while red/blue stream writes
      exp_wr_q.push_back(mk_wr(8'h20, c_red, 1'b1, 1'b0, 1'b0));
      exp_wr_q.push_back(mk_wr(8'h34, c_blue, 1'b0, 1'b1, 1'b0));
      exp_wr_q.push_back(mk_wr(8'h21, c_red, 1'b1, 1'b0, 1'b0));
      exp_wr_q.push_back(mk_wr(8'h35, c_blue, 1'b0, 1'b1, 1'b0));
      exp_wr_q.push_back(mk_wr(8'h22, c_red, 1'b1, 1'b0, 1'b0));
      exp_wr_q.push_back(mk_wr(8'h23, c_red, 1'b1, 1'b0, 1'b0));
      exp_rd_q.push_back(3'b101);
      fork
         begin
            red_write(4'd0, 4'd2, l1);
            red_write(4'd1, 4'd2, l1);
            red_write(4'd2, 4'd2, l1);
            red_write(4'd3, 4'd2, l1);
         end
         begin
            blue_write(4'd4, 4'd3, l2);
            blue_write(4'd5, 4'd3, l2);
         end
         draw_read(8'h10, ld);
      join
      chk_eq("draw_starve_lat", 32'(ld), 32'(STARVE_LIMIT + 1));
      repeat (RD_LAT + 2) @(posedge clock);
      #1;
      chk_eq("starve_reads_done", 32'(exp_rd_q.size()), 32'd0);

      // Reset asserted while a read is in flight
      draw_addr = 8'h10; draw_req = 1'b1; got_ack = 1'b0;
      for (int i = 0; i < 20 && !got_ack; i++) begin
         @(negedge clock);
         if (draw_ack) got_ack = 1'b1;
      end
      chk_eq("reset_read_ack", 32'(got_ack), 32'd1);
      #2;
      draw_req = 1'b0;
      reset    = 1'b0;
      #1 check_all_zero("midreset");
      rd_due_q.delete();
      exp_rd_q.delete();
      repeat (3) @(posedge clock);
      @(negedge clock) reset = 1'b1;
      repeat (RD_LAT + 3) @(posedge clock);
      #1;

      // Arbitration resumes right after release
      exp_wr_q.push_back(mk_wr(8'hFF, c_red, 1'b1, 1'b0, 1'b0));
      red_write(4'd15, 4'd15, l1);
      chk_eq("post_reset_red_lat", 32'(l1), 32'd1);
      repeat (3) @(posedge clock);
      #1;

      chk_eq("wr_queue_drained", 32'(exp_wr_q.size()), 32'd0);
      chk_eq("rd_queue_drained", 32'(rd_due_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
